// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared DDR read-channel parameters, id-width helper and the in-flight tag type
// used by the read arbiter and its tag FIFO.
package GLOBAL_PARAM;

  localparam int DDR_W      = 64;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;

  function automatic int bw(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int RD_REQ_NUM = 4;
  localparam int RD_TAG_W   = bw(RD_REQ_NUM);

  typedef struct packed {
    logic [RD_TAG_W-1:0] id;
    logic [BURST_W-1:0]  size;
  } rd_tag_t;

endpackage

// File: rtl/ddr_rd_arbiter_tag_fifo.sv
// Synchronous FIFO of in-flight read tags; head entry is valid whenever not empty.
// Simultaneous push and pop is accepted even when full.
module ddr_tag_fifo
  import GLOBAL_PARAM::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rd_tag_t                  push_tag,
  input  logic                     pop,
  output rd_tag_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t        mem_q [DEPTH];
  rd_tag_t        mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           push_ok_s, pop_ok_s;

  assign empty = (cnt_q == (AW+1)'(0));
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage next-state
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin sharing of one DDR read channel among burst requesters; returning
// beats are steered to the issuing requester via an in-flight tag FIFO.
module ddr_rd_arbiter
  import GLOBAL_PARAM::*;
#(
  parameter int REQ_NUM     = 4,
  parameter int OUTSTANDING = 8,
  parameter int TAG_W       = bw(REQ_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_NUM-1:0]                   req_valid,
  output logic [REQ_NUM-1:0]                   req_ready,
  input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]   req_addr,
  input  logic [REQ_NUM-1:0][BURST_W-1:0]      req_size,
  output logic [DDR_ADDR_W-1:0]                ddr_addr,
  output logic [BURST_W-1:0]                   ddr_size,
  output logic                                 ddr_addr_valid,
  input  logic                                 ddr_addr_ready,
  input  logic [DDR_W-1:0]                     ddr_data,
  input  logic                                 ddr_valid,
  output logic                                 ddr_ready,
  output logic [DDR_W-1:0]                     rd_data,
  output logic [REQ_NUM-1:0]                   rd_valid,
  input  logic [REQ_NUM-1:0]                   rd_ready,
  output logic                                 rd_last,
  output logic                                 busy
);

  localparam int          CW      = $clog2(OUTSTANDING) + 1;
  localparam logic [CW:0] OUT_LIM = (CW+1)'(OUTSTANDING);

  function automatic logic [TAG_W-1:0] rr_add(input logic [TAG_W-1:0] base, input int k);
    logic [TAG_W:0] sum;
    sum = {1'b0, base} + (TAG_W+1)'(k);
    if (sum >= (TAG_W+1)'(REQ_NUM)) begin
      sum = sum - (TAG_W+1)'(REQ_NUM);
    end else begin
      sum = sum;
    end
    return sum[TAG_W-1:0];
  endfunction

  logic [DDR_ADDR_W-1:0] addr_q, addr_d;
  logic [BURST_W-1:0]    size_q, size_d;
  logic [TAG_W-1:0]      id_q, id_d;
  logic                  pend_q, pend_d;
  logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                  hs_s, found_s, credit_ok_s, grant_en_s;
  logic [TAG_W-1:0]      gnt_id_s, cand_s, hid_s;
  logic [CW:0]           inflight_s;
  logic [CW-1:0]         fifo_count_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic                  accept_s, pop_s;
  rd_tag_t               push_tag_s, head_s;

  // Round-robin search and grant; the pending slot may be refilled in its handshake cycle
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    cand_s   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand_s   = rr_add(rr_ptr_q, k);
      gnt_id_s = (!found_s && req_valid[cand_s]) ? cand_s : gnt_id_s;
      found_s  = found_s | req_valid[cand_s];
    end
    hs_s        = pend_q && ddr_addr_ready;
    inflight_s  = {1'b0, fifo_count_s} + {{CW{1'b0}}, pend_q};
    credit_ok_s = (inflight_s < OUT_LIM) && !fifo_full_s;
    grant_en_s  = rst && found_s && credit_ok_s && (!pend_q || hs_s);
    req_ready   = grant_en_s ? (REQ_NUM'(1) << gnt_id_s) : '0;
  end

  // Address slot next-state
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    id_d     = id_q;
    pend_d   = pend_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_en_s) begin
      addr_d   = req_addr[gnt_id_s];
      size_d   = req_size[gnt_id_s];
      id_d     = gnt_id_s;
      pend_d   = 1'b1;
      rr_ptr_d = rr_add(gnt_id_s, 1);
    end else if (hs_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  assign push_tag_s.id   = id_q;
  assign push_tag_s.size = size_q;

  ddr_tag_fifo #(
    .DEPTH    (OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (hs_s),
    .push_tag (push_tag_s),
    .pop      (pop_s),
    .head     (head_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Return steering to the head burst's owner; stalls when nothing is in flight
  always_comb begin
    hid_s      = head_s.id;
    ddr_ready  = !fifo_empty_s && rd_ready[hid_s];
    rd_valid   = (ddr_valid && !fifo_empty_s) ? (REQ_NUM'(1) << hid_s) : '0;
    rd_last    = !fifo_empty_s && (beat_cnt_q == head_s.size);
    accept_s   = ddr_valid && ddr_ready;
    pop_s      = accept_s && rd_last;
    beat_cnt_d = beat_cnt_q;
    if (accept_s) begin
      beat_cnt_d = rd_last ? '0 : (beat_cnt_q + BURST_W'(1));
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  assign rd_data        = ddr_data;
  assign ddr_addr       = addr_q;
  assign ddr_size       = size_q;
  assign ddr_addr_valid = pend_q;
  assign busy           = pend_q || !fifo_empty_s;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      size_q     <= '0;
      id_q       <= '0;
      pend_q     <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      size_q     <= size_d;
      id_q       <= id_d;
      pend_q     <= pend_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Shares one DDR read channel (address + data stream) among `REQ_NUM` burst requesters: the index, data, partial-sum and accumulator/bias loaders. It serialises their burst requests onto the DDR address port with round-robin arbitration. It tracks in-flight bursts in a tag FIFO and steers each returning data beat to the requester that issued the burst. It sits between the per-buffer DDR address generators and one DDR read port.

## Interface
Parameters:
- `REQ_NUM`, 4: number of requesters.
- `OUTSTANDING`, 8: maximum in-flight bursts; a power of two, at least 2.
- `TAG_W`, `bw(REQ_NUM)`: requester-id width.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req_valid`  in  REQ_NUM: burst request per requester.
- `req_ready`  out  REQ_NUM: one-hot, one-cycle grant; the request is consumed.
- `req_addr`  in  [REQ_NUM][DDR_ADDR_W]: burst start address.
- `req_size`  in  [REQ_NUM][BURST_W]: burst length in beats minus 1.
- `ddr_addr`  out  DDR_ADDR_W: DDR read address.
- `ddr_size`  out  BURST_W: DDR burst length.
- `ddr_addr_valid`  out  1: DDR address handshake, valid.
- `ddr_addr_ready`  in  1: DDR address handshake, ready.
- `ddr_data`  in  DDR_W: returning read beat.
- `ddr_valid`  in  1: returning beat valid.
- `ddr_ready`  out  1: returning beat accepted.
- `rd_data`  out  DDR_W: `ddr_data` broadcast to all requesters.
- `rd_valid`  out  REQ_NUM: one-hot beat valid, routed to the owner.
- `rd_ready`  in  REQ_NUM: per-requester beat acceptance.
- `rd_last`  out  1: current beat is the final beat of its burst.
- `busy`  out  1: an address is pending or the tag FIFO is not empty.

## Operation
- Address stage:
  - One registered slot holds `{addr, size, id}` and a `pend` flag.
  - The arbiter runs when `!pend` and `credits = OUTSTANDING - fifo_count - pend > 0`.
- Arbitration is round-robin:
  - The search starts at `rr_ptr`; the first `req_valid[i]` found wins.
  - On a grant: `req_ready[i]=1`, the slot loads, `pend=1`, `rr_ptr = i+1 mod REQ_NUM`.
  - After reset `rr_ptr=0`.
- Address handshake: on `ddr_addr_valid && ddr_addr_ready`, push `{id, size}` into the tag FIFO and clear `pend`. A new grant may happen in the same cycle if credits allow.
- Return stage:
  - The FIFO head gives `(hid, hsize)`; `beat_cnt` counts accepted beats of the head burst.
  - `rd_valid[hid] = ddr_valid && !empty`; all other bits are 0.
  - `ddr_ready = !empty && rd_ready[hid]`.
  - `rd_last = !empty && (beat_cnt == hsize)`.
- When a beat is accepted: if `rd_last`, pop the FIFO and set `beat_cnt=0`; otherwise `beat_cnt++`.
- `ddr_valid` arriving while the FIFO is empty is a protocol error: `ddr_ready=0` (stall), nothing is routed.
- `req_size`/`ddr_size` follow the same minus-1 encoding. `beat_cnt` is `BURST_W` wide and never wraps within a burst.

## Timing
- Reset values:
  - `req_ready=0`, `ddr_addr_valid=0`, `ddr_addr=0`, `ddr_size=0`.
  - `pend=0`, `rr_ptr=0`, FIFO empty, `beat_cnt=0`.
  - `ddr_ready=0`, `rd_valid=0`, `rd_last=0`, `busy=0`.
- Grant is combinational on `req_valid` and registered into the slot. `ddr_addr_valid` rises the cycle after `req_ready`, and `ddr_addr`/`ddr_size` hold stable until the handshake.
- Back-to-back throughput: one address per cycle while `ddr_addr_ready=1` and credits remain. Grant and handshake can occur in the same cycle.
- The data path is zero-latency combinational: `ddr_data` → `rd_data`, `rd_ready` → `ddr_ready`. There are no bubbles between bursts; the pop and the next head's first beat are in consecutive cycles.
- FIFO push and pop in the same cycle leave the count unchanged, and this is legal when full. Credits are computed from the pre-update count, so there is never overflow.
- A requester dropping `req_valid` without a grant is allowed.
- `rst` asserted mid-burst discards all in-flight tags immediately. Beats still returning afterwards stall, because the FIFO is empty.

## Structure
- Shared package `GLOBAL_PARAM` supplies `DDR_W`, `DDR_ADDR_W`, `BURST_W` and `bw()`.
- Add to the package the typedef `rd_tag_t` = packed struct `{id[TAG_W], size[BURST_W]}`.
- Sub-module `ddr_tag_fifo`: synchronous FIFO of `rd_tag_t`, depth `OUTSTANDING`, with `count`, `full` and `empty` outputs, and head data valid while not empty.
- Round-robin arbiter and beat counter are inline.

## Test plan
- Single requester: `req_addr[2]=0x1000`, `req_size[2]=3`; DDR returns 4 beats `A..D` → `ddr_addr=0x1000`, `ddr_size=3`; `rd_valid=4'b0100` for 4 beats; `rd_last` on `D` only; `busy` falls after `D`.
- All 4 requesting continuously with `ddr_addr_ready=1` → grant order 0,1,2,3,0, one grant per cycle; returned bursts route to ids in issue order.
- Credit limit, `OUTSTANDING=8`, DDR data withheld → exactly 8 address handshakes, then `req_ready` stays 0. Releasing one full burst allows exactly one more grant.
- `rd_ready[1]` held low mid-burst for 5 cycles → `ddr_ready=0` for those cycles, no beat lost or duplicated, `beat_cnt` resumes.
- `ddr_valid=1` with the FIFO empty → `ddr_ready=0`, `rd_valid=0`.
- `rst` pulsed low during the third beat of an 8-beat burst → all outputs return to reset values asynchronously. The next request after release is granted from `rr_ptr=0`.
